// File: rtl/ifetch_icache_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC,
// memory read length and fetch FSM state encodings.
package ifetch_icache_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Every instruction read asks the memory controller for one 4-byte word.
  localparam logic [3:0] FETCH_LEN = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch_icache_array.sv
// Direct-mapped instruction cache storage: one-word lines, a combinational
// read port and a synchronous write port; valid bits clear on reset.
module ifetch_icache_array
  import ifetch_icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = ADDR_WIDTH - 2 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [INST_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [INST_WIDTH-1:0] wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags  [LINES];
  logic [INST_WIDTH-1:0] words [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; a line is only trusted once its
  // valid bit is set, so clearing the valid vector is sufficient.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = words[rd_index];

endmodule

// File: rtl/ifetch_icache.sv
// Fetch stage: holds the PC, serves hits from a direct-mapped I-cache one word
// per cycle, and fills misses through a single-word memory controller read.
module ifetch_icache
  import ifetch_icache_pkg::*;
#(
  parameter int                    INDEX_BITS = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] clear_pc,
  input  logic                  iq_full,
  output logic                  ins_valid,
  output logic [INST_WIDTH-1:0] ins_data,
  output logic [ADDR_WIDTH-1:0] ins_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_len,
  input  logic                  mem_ok,
  input  logic [INST_WIDTH-1:0] mem_data
);

  localparam int TAG_BITS = ADDR_WIDTH - 2 - INDEX_BITS;

  fetch_state_e          state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic                  pend_v, pend_v_next;
  logic [INST_WIDTH-1:0] pend_data, pend_data_next;
  logic                  ins_valid_next;
  logic [INST_WIDTH-1:0] ins_data_next;
  logic [ADDR_WIDTH-1:0] ins_pc_next;
  logic                  mem_req_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic                  fill;

  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [INST_WIDTH-1:0] line_data;
  logic                  hit;

  assign pc_index = pc[INDEX_BITS+1:2];
  assign pc_tag   = pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign hit      = line_valid && (line_tag == pc_tag);
  assign mem_len  = FETCH_LEN;

  // While in MISS the PC still names the missing word, so it also addresses the fill.
  ifetch_icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (pc_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill && rdy),
    .wr_index (pc_index),
    .wr_tag   (pc_tag),
    .wr_data  (mem_data)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next     = state;
    pc_next        = pc;
    pend_v_next    = pend_v;
    pend_data_next = pend_data;
    ins_valid_next = 1'b0;
    ins_data_next  = ins_data;
    ins_pc_next    = ins_pc;
    mem_req_next   = 1'b0;
    mem_addr_next  = mem_addr;
    fill           = 1'b0;

    if (clear) begin
      // Redirect drops any outstanding miss; a coincident mem_ok is discarded.
      pc_next     = clear_pc & ~32'h3;
      state_next  = ST_IDLE;
      pend_v_next = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!iq_full) begin
            if (hit) begin
              ins_valid_next = 1'b1;
              ins_data_next  = line_data;
              ins_pc_next    = pc;
              pc_next        = pc + 32'd4;
            end else begin
              mem_req_next  = 1'b1;
              mem_addr_next = pc;
              state_next    = ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (mem_ok) begin
            fill    = 1'b1;
            pc_next = pc + 32'd4;
            if (!iq_full) begin
              ins_valid_next = 1'b1;
              ins_data_next  = mem_data;
              ins_pc_next    = mem_addr;
              state_next     = ST_IDLE;
            end else begin
              pend_data_next = mem_data;
              pend_v_next    = 1'b1;
              state_next     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // mem_addr still holds the address of the parked word.
          if (!iq_full && pend_v) begin
            ins_valid_next = 1'b1;
            ins_data_next  = pend_data;
            ins_pc_next    = mem_addr;
            pend_v_next    = 1'b0;
            state_next     = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values computed before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      pend_v    <= 1'b0;
      pend_data <= '0;
      ins_valid <= 1'b0;
      ins_data  <= '0;
      ins_pc    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else if (rdy) begin
      state     <= state_next;
      pc        <= pc_next;
      pend_v    <= pend_v_next;
      pend_data <= pend_data_next;
      ins_valid <= ins_valid_next;
      ins_data  <= ins_data_next;
      ins_pc    <= ins_pc_next;
      mem_req   <= mem_req_next;
      mem_addr  <= mem_addr_next;
    end
  end

endmodule

// File: tb/tb_ifetch_icache.sv
// Randomized scoreboard bench for ifetch_icache: an address-level cache model
// predicts each ins_valid/mem_req pulse and the edge it must appear on.
module tb_ifetch_icache;

  localparam int          INDEX_BITS = 6;
  localparam int          LINES      = 1 << INDEX_BITS;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, rdy, clear, iq_full, mem_ok;
  logic [31:0] clear_pc, mem_data;
  logic        ins_valid, mem_req;
  logic [31:0] ins_data, ins_pc, mem_addr;
  logic [3:0]  mem_len;

  always #5 clk = ~clk;

  ifetch_icache #(
    .INDEX_BITS (INDEX_BITS),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clear     (clear),
    .clear_pc  (clear_pc),
    .iq_full   (iq_full),
    .ins_valid (ins_valid),
    .ins_data  (ins_data),
    .ins_pc    (ins_pc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_len   (mem_len),
    .mem_ok    (mem_ok),
    .mem_data  (mem_data)
  );

  typedef struct {
    int unsigned stamp;
    logic [31:0] pc;
    logic [31:0] data;
  } ins_exp_t;

  typedef struct {
    int unsigned stamp;
    logic [31:0] addr;
  } req_exp_t;

  typedef enum {M_FETCH, M_WAIT, M_STALL} mode_e;

  ins_exp_t    exp_ins[$];
  req_exp_t    exp_req[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned edge_n = 0;
  logic        next_active = 1'b0;
  logic        last_active = 1'b0;

  // Reference model: a table of which word address each line currently holds.
  mode_e       mode;
  logic [31:0] m_pc, m_miss_addr, m_stall_data;
  logic        m_valid [LINES];
  logic [31:0] m_addr  [LINES];
  logic [31:0] m_line  [LINES];

  // Memory controller model.
  bit          busy;
  int          cnt;
  logic [31:0] raddr;

  always @(posedge clk) begin
    edge_n      <= edge_n + 1;
    last_active <= next_active;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a / 4) % LINES;
  endfunction

  function automatic logic [31:0] pick_pc();
    logic [31:0] base;
    case ($urandom_range(0, 4))
      0:       base = 32'h0000_0000;
      1:       base = 32'h0000_0100;
      2:       base = 32'h0000_1000;
      3:       base = 32'hFFFF_FFE0;
      default: base = $urandom & ~32'h1F;
    endcase
    return base + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at edge %0d", name, act, exp, edge_n);
    end
  endtask

  task automatic push_ins(input int unsigned s, input logic [31:0] pc, input logic [31:0] data);
    ins_exp_t e;
    e.stamp = s;
    e.pc    = pc;
    e.data  = data;
    exp_ins.push_back(e);
  endtask

  task automatic push_req(input int unsigned s, input logic [31:0] addr);
    req_exp_t r;
    r.stamp = s;
    r.addr  = addr;
    exp_req.push_back(r);
  endtask

  // Advance the model by the upcoming edge, using the inputs just driven.
  task automatic model_step();
    int unsigned s;
    int unsigned li;
    s           = edge_n + 1;
    next_active = rdy && !rst;
    if (rst) begin
      m_pc = RESET_PC;
      mode = M_FETCH;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else if (rdy) begin
      if (clear) begin
        m_pc = clear_pc & ~32'h3;
        mode = M_FETCH;
      end else begin
        case (mode)
          M_FETCH: begin
            if (!iq_full) begin
              li = line_of(m_pc);
              if (m_valid[li] && m_addr[li] == m_pc) begin
                push_ins(s, m_pc, m_line[li]);
                m_pc = m_pc + 32'd4;
              end else begin
                push_req(s, m_pc);
                m_miss_addr = m_pc;
                mode        = M_WAIT;
              end
            end
          end
          M_WAIT: begin
            if (mem_ok) begin
              li          = line_of(m_miss_addr);
              m_valid[li] = 1'b1;
              m_addr[li]  = m_miss_addr;
              m_line[li]  = mem_data;
              m_pc        = m_pc + 32'd4;
              if (!iq_full) begin
                push_ins(s, m_miss_addr, mem_data);
                mode = M_FETCH;
              end else begin
                m_stall_data = mem_data;
                mode         = M_STALL;
              end
            end
          end
          M_STALL: begin
            if (!iq_full) begin
              push_ins(s, m_miss_addr, m_stall_data);
              mode = M_FETCH;
            end
          end
          default: mode = M_FETCH;
        endcase
      end
    end
  endtask

  task automatic drive_cycle(input int cyc, input bit drain);
    bit fire;
    rst = !drain && (cyc == 2000);
    if (drain)                                   rdy = 1'b1;
    else if (rst || (cyc >= 1200 && cyc < 1205)) rdy = 1'b0;
    else                                         rdy = ($urandom_range(0, 11) != 0);
    if (rst) busy = 1'b0;
    if (drain) iq_full = (mode == M_FETCH);
    else       iq_full = (cyc >= 200) && ($urandom_range(0, 3) == 0);
    fire     = rdy && !rst && busy && (cnt == 0);
    mem_ok   = fire;
    mem_data = fire ? mem_word(raddr) : $urandom;
    // Stray completions outside a miss must be ignored.
    if (!drain && !fire && mode != M_WAIT && $urandom_range(0, 15) == 0) mem_ok = 1'b1;
    clear    = !drain && (($urandom_range(0, 29) == 0) || (fire && $urandom_range(0, 3) == 0));
    clear_pc = pick_pc();
    if (fire) busy = 1'b0;
    else if (busy && rdy && !rst) begin
      if (clear) busy = 1'b0;
      else       cnt--;
    end
    model_step();
    @(posedge clk);
    #1;
    if (last_active && mem_req) begin
      busy  = 1'b1;
      cnt   = $urandom_range(1, 7);
      raddr = mem_addr;
    end
  endtask

  task automatic check_reset_outputs();
    check("reset ins_valid", 32'(ins_valid), 32'd0);
    check("reset ins_data",  ins_data,       32'd0);
    check("reset ins_pc",    ins_pc,         32'd0);
    check("reset mem_req",   32'(mem_req),   32'd0);
    check("reset mem_addr",  mem_addr,       32'd0);
    check("reset mem_len",   32'(mem_len),   32'd4);
  endtask

  // Monitor: compares every pulse the DUT presents against the scoreboard.
  always @(negedge clk) begin
    ins_exp_t e;
    req_exp_t r;
    if (last_active) begin
      if (ins_valid) begin
        check("ins_valid expected", 32'(exp_ins.size() != 0), 32'd1);
        if (exp_ins.size() != 0) begin
          e = exp_ins.pop_front();
          check("ins_valid edge", edge_n,   e.stamp);
          check("ins_pc",         ins_pc,   e.pc);
          check("ins_data",       ins_data, e.data);
        end
      end
      if (mem_req) begin
        check("mem_req expected", 32'(exp_req.size() != 0), 32'd1);
        check("mem_len",          32'(mem_len),             32'd4);
        if (exp_req.size() != 0) begin
          r = exp_req.pop_front();
          check("mem_req edge", edge_n,   r.stamp);
          check("mem_addr",     mem_addr, r.addr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rdy      = 1'b1;
    clear    = 1'b0;
    clear_pc = 32'h0;
    iq_full  = 1'b0;
    mem_ok   = 1'b0;
    mem_data = 32'h0;
    busy     = 1'b0;
    cnt      = 0;
    raddr    = 32'h0;
    model_step();
    @(posedge clk);
    #1;
    // Reset must win over a frozen pipeline.
    rdy = 1'b0;
    model_step();
    @(posedge clk);
    #1;
    check_reset_outputs();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2001) check_reset_outputs();
      drive_cycle(cyc, 1'b0);
    end
    for (int d = 0; d < 40; d++) drive_cycle(0, 1'b1);
    @(negedge clk);
    #1;
    check("ins scoreboard drained", 32'(exp_ins.size()), 32'd0);
    check("req scoreboard drained", 32'(exp_req.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
